// File: rtl/robo_pkg.sv
// Shared types and helpers for the robot arena model.
// Heading/state encodings and neighbour-cell arithmetic.
package robo_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_TURN   = 2'd2,
        ST_REMOVE = 2'd3
    } state_t;

    typedef struct packed {
        logic       oob;
        logic [3:0] x;
        logic [3:0] y;
    } nbr_t;

    // Edge test happens before the add/sub; on oob the pose is returned
    // unchanged so any derived index still lands inside the grid.
    function automatic nbr_t neighbour(
        input logic [3:0] x,
        input logic [3:0] y,
        input dir_t       d,
        input logic [4:0] w,
        input logic [4:0] h
    );
        nbr_t n;
        n = '{oob: 1'b0, x: x, y: y};
        case (d)
            DIR_N: if (y == 4'd0) n.oob = 1'b1;
                   else n.y = y - 4'd1;
            DIR_E: if ({1'b0, x} == w - 5'd1) n.oob = 1'b1;
                   else n.x = x + 4'd1;
            DIR_S: if ({1'b0, y} == h - 5'd1) n.oob = 1'b1;
                   else n.y = y + 4'd1;
            DIR_W: if (x == 4'd0) n.oob = 1'b1;
                   else n.x = x - 4'd1;
            default: n.oob = 1'b1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/robo_cell_lookup.sv
// Neighbour-cell lookup: wall/obstacle/mark bits of the cell one step
// from (x,y) in a given direction; outside cells read as wall.
module robo_cell_lookup
    import robo_pkg::*;
#(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8
) (
    input  logic [3:0]               x_i,
    input  logic [3:0]               y_i,
    input  dir_t                     dir_i,
    input  logic [GRID_W*GRID_H-1:0] wall_i,
    input  logic [GRID_W*GRID_H-1:0] mark_i,
    input  logic [GRID_W*GRID_H-1:0] obst_i,
    output logic                     wall_o,
    output logic                     obst_o,
    output logic                     mark_o,
    output logic                     oob_o,
    output logic [7:0]               idx_o
);

    localparam int N = GRID_W * GRID_H;

    nbr_t         n;
    logic [N-1:0] wall_sh;
    logic [N-1:0] mark_sh;
    logic [N-1:0] obst_sh;

    always_comb begin
        n = neighbour(x_i, y_i, dir_i, 5'(GRID_W), 5'(GRID_H));
    end

    assign idx_o   = 8'(int'(n.y) * GRID_W + int'(n.x));
    assign wall_sh = wall_i >> idx_o;
    assign mark_sh = mark_i >> idx_o;
    assign obst_sh = obst_i >> idx_o;

    assign oob_o  = n.oob;
    assign wall_o = n.oob | wall_sh[0];
    assign obst_o = ~n.oob & obst_sh[0];
    assign mark_o = ~n.oob & mark_sh[0];

endmodule

// File: rtl/robo_arena.sv
// Robot arena: grid world with walls, marks and removable obstacles,
// executing forward/turn/remove commands and producing registered sensors.
module robo_arena
    import robo_pkg::*;
#(
    parameter int                         GRID_W        = 8,
    parameter int                         GRID_H        = 8,
    parameter logic [GRID_W*GRID_H-1:0]   WALL_MAP      = '0,
    parameter logic [GRID_W*GRID_H-1:0]   MARK_MAP      = '0,
    parameter logic [GRID_W*GRID_H-1:0]   OBST_MAP      = '0,
    parameter int                         X0            = 0,
    parameter int                         Y0            = 0,
    parameter int                         DIR0          = 0,
    parameter int                         MOVE_CYCLES   = 4,
    parameter int                         TURN_CYCLES   = 2,
    parameter int                         REMOVE_CYCLES = 6
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        forward,
    input  logic                        turn,
    input  logic                        remove,
    output logic                        head,
    output logic                        left,
    output logic                        under,
    output logic                        barrier,
    output logic [$clog2(GRID_W)-1:0]   pos_x,
    output logic [$clog2(GRID_H)-1:0]   pos_y,
    output logic [1:0]                  heading,
    output logic                        busy,
    output logic                        collision,
    output logic                        illegal_cmd,
    output logic [7:0]                  obst_left
);

    localparam int N  = GRID_W * GRID_H;
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    // Sensor values for the reset pose, so they are valid during reset.
    localparam nbr_t R_A = neighbour(4'(X0), 4'(Y0), dir_t'(2'(DIR0)),
                                     5'(GRID_W), 5'(GRID_H));
    localparam nbr_t R_L = neighbour(4'(X0), 4'(Y0), dir_t'(2'(DIR0 + 3)),
                                     5'(GRID_W), 5'(GRID_H));
    localparam int R_AI = int'(R_A.y) * GRID_W + int'(R_A.x);
    localparam int R_LI = int'(R_L.y) * GRID_W + int'(R_L.x);
    localparam logic [N-1:0] R_WA = WALL_MAP >> R_AI;
    localparam logic [N-1:0] R_OA = OBST_MAP >> R_AI;
    localparam logic [N-1:0] R_WL = WALL_MAP >> R_LI;
    localparam logic [N-1:0] R_MC = MARK_MAP >> (Y0 * GRID_W + X0);
    localparam logic [7:0]   R_NOB = 8'($countones(OBST_MAP));

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    dir_t          hd_q, hd_d;
    logic [N-1:0]  obst_q, obst_d;
    logic [7:0]    nob_q, nob_d;
    logic          blk_q, blk_d;
    logic          busy_q, busy_d;
    logic          coll_q, coll_d;
    logic          ill_q, ill_d;
    logic          head_q, head_d;
    logic          left_q, left_d;
    logic          under_q, under_d;
    logic          bar_q, bar_d;

    logic [1:0]    ncmd;
    logic          one_cmd;
    logic          multi_cmd;
    logic [3:0]    x4, y4;
    dir_t          l_dir;
    logic [7:0]    cur_idx;
    logic [N-1:0]  mark_sh;

    logic          a_wall, a_obst, a_mark, a_oob;
    logic [7:0]    a_idx;
    logic          l_wall, l_obst, l_mark, l_oob;
    logic [7:0]    l_idx;
    logic          unused_ok;

    assign ncmd      = 2'(forward) + 2'(turn) + 2'(remove);
    assign one_cmd   = (ncmd == 2'd1);
    assign multi_cmd = (ncmd >= 2'd2);
    assign x4        = 4'(x_q);
    assign y4        = 4'(y_q);
    assign l_dir     = dir_t'(hd_q - 2'd1);
    assign cur_idx   = 8'(int'(y_q) * GRID_W + int'(x_q));
    assign mark_sh   = MARK_MAP >> cur_idx;

    robo_cell_lookup #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_ahead (
        .x_i    (x4),
        .y_i    (y4),
        .dir_i  (hd_q),
        .wall_i (WALL_MAP),
        .mark_i (MARK_MAP),
        .obst_i (obst_q),
        .wall_o (a_wall),
        .obst_o (a_obst),
        .mark_o (a_mark),
        .oob_o  (a_oob),
        .idx_o  (a_idx)
    );

    robo_cell_lookup #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_left (
        .x_i    (x4),
        .y_i    (y4),
        .dir_i  (l_dir),
        .wall_i (WALL_MAP),
        .mark_i (MARK_MAP),
        .obst_i (obst_q),
        .wall_o (l_wall),
        .obst_o (l_obst),
        .mark_o (l_mark),
        .oob_o  (l_oob),
        .idx_o  (l_idx)
    );

    assign unused_ok = ^{a_mark, a_oob, l_obst, l_mark, l_oob, l_idx};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (one_cmd) begin
                    unique case (1'b1)
                        forward: begin
                            state_d = ST_MOVE;
                            cnt_d   = 8'(MOVE_CYCLES - 1);
                        end
                        turn: begin
                            state_d = ST_TURN;
                            cnt_d   = 8'(TURN_CYCLES - 1);
                        end
                        remove: begin
                            state_d = ST_REMOVE;
                            cnt_d   = 8'(REMOVE_CYCLES - 1);
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                if (cnt_q == 8'd0) state_d = ST_IDLE;
                else cnt_d = cnt_q - 8'd1;
            end
        endcase
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        hd_d    = hd_q;
        obst_d  = obst_q;
        nob_d   = nob_q;
        blk_d   = blk_q;
        busy_d  = (state_d != ST_IDLE);
        coll_d  = 1'b0;
        ill_d   = 1'b0;
        head_d  = head_q;
        left_d  = left_q;
        under_d = under_q;
        bar_d   = bar_q;
        case (state_q)
            ST_IDLE: begin
                head_d  = a_wall;
                left_d  = l_wall;
                under_d = mark_sh[0];
                bar_d   = a_obst;
                ill_d   = multi_cmd;
                if (one_cmd && forward) begin
                    blk_d  = a_wall | a_obst;
                    coll_d = a_wall | a_obst;
                end
            end
            ST_MOVE: begin
                if (cnt_q == 8'd0 && !blk_q) begin
                    case (hd_q)
                        DIR_N:   y_d = y_q - YW'(1);
                        DIR_E:   x_d = x_q + XW'(1);
                        DIR_S:   y_d = y_q + YW'(1);
                        DIR_W:   x_d = x_q - XW'(1);
                        default: ;
                    endcase
                end
            end
            ST_TURN: begin
                if (cnt_q == 8'd0) hd_d = dir_t'(hd_q + 2'd1);
            end
            ST_REMOVE: begin
                if (cnt_q == 8'd0 && a_obst) begin
                    obst_d = obst_q & ~(N'(1) << a_idx);
                    nob_d  = nob_q - 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q     <= XW'(X0);
            y_q     <= YW'(Y0);
            hd_q    <= dir_t'(2'(DIR0));
            obst_q  <= OBST_MAP;
            nob_q   <= R_NOB;
            blk_q   <= 1'b0;
            busy_q  <= 1'b0;
            coll_q  <= 1'b0;
            ill_q   <= 1'b0;
            head_q  <= R_A.oob | R_WA[0];
            left_q  <= R_L.oob | R_WL[0];
            under_q <= R_MC[0];
            bar_q   <= ~R_A.oob & R_OA[0];
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hd_q    <= hd_d;
            obst_q  <= obst_d;
            nob_q   <= nob_d;
            blk_q   <= blk_d;
            busy_q  <= busy_d;
            coll_q  <= coll_d;
            ill_q   <= ill_d;
            head_q  <= head_d;
            left_q  <= left_d;
            under_q <= under_d;
            bar_q   <= bar_d;
        end
    end

    assign head        = head_q;
    assign left        = left_q;
    assign under       = under_q;
    assign barrier     = bar_q;
    assign pos_x       = x_q;
    assign pos_y       = y_q;
    assign heading     = hd_q;
    assign busy        = busy_q;
    assign collision   = coll_q;
    assign illegal_cmd = ill_q;
    assign obst_left   = nob_q;

endmodule

// File: tb/tb_robo_arena.sv
// Directed bench for robo_arena: 8x8 grid, start (0,0) facing E,
// mark at (1,0), obstacle at (2,0), wall at (2,1).
module tb_robo_arena;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       forward = 1'b0;
    logic       turn = 1'b0;
    logic       remove = 1'b0;
    logic       head, left, under, barrier;
    logic [2:0] pos_x, pos_y;
    logic [1:0] heading;
    logic       busy, collision, illegal_cmd;
    logic [7:0] obst_left;

    int n_run  = 0;
    int n_fail = 0;

    robo_arena #(
        .GRID_W        (8),
        .GRID_H        (8),
        .WALL_MAP      (64'h0000_0000_0000_0400),
        .MARK_MAP      (64'h0000_0000_0000_0002),
        .OBST_MAP      (64'h0000_0000_0000_0004),
        .X0            (0),
        .Y0            (0),
        .DIR0          (1),
        .MOVE_CYCLES   (4),
        .TURN_CYCLES   (2),
        .REMOVE_CYCLES (6)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .forward     (forward),
        .turn        (turn),
        .remove      (remove),
        .head        (head),
        .left        (left),
        .under       (under),
        .barrier     (barrier),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .heading     (heading),
        .busy        (busy),
        .collision   (collision),
        .illegal_cmd (illegal_cmd),
        .obst_left   (obst_left)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic issue(input logic f, input logic t, input logic r);
        @(negedge clock);
        forward = f;
        turn    = t;
        remove  = r;
        @(negedge clock);
        forward = 1'b0;
        turn    = 1'b0;
        remove  = 1'b0;
    endtask

    task automatic run_busy(output int cyc, output int ncoll,
                            output int hd_all);
        cyc    = 0;
        ncoll  = 0;
        hd_all = 1;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (collision === 1'b1) ncoll++;
            if (head !== 1'b1) hd_all = 0;
            @(negedge clock);
        end
    endtask

    task automatic do_turn(input string tag, input int hd,
                           input int hx, input int lx);
        int cyc, nc, ha;
        issue(1'b0, 1'b1, 1'b0);
        run_busy(cyc, nc, ha);
        check({tag, "_cyc"}, cyc, 2);
        @(negedge clock);
        check({tag, "_hdg"}, int'(heading), hd);
        check({tag, "_head"}, int'(head), hx);
        check({tag, "_left"}, int'(left), lx);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, nc, ha;

        repeat (2) @(negedge clock);
        check("rst_head", int'(head), 0);
        check("rst_left", int'(left), 1);
        check("rst_under", int'(under), 0);
        check("rst_barrier", int'(barrier), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_obst", int'(obst_left), 1);
        check("rst_x", int'(pos_x), 0);
        check("rst_y", int'(pos_y), 0);
        check("rst_hdg", int'(heading), 1);
        check("rst_coll", int'(collision), 0);
        check("rst_ill", int'(illegal_cmd), 0);
        reset = 1'b0;

        // step onto the marked cell
        issue(1'b1, 1'b0, 1'b0);
        run_busy(cyc, nc, ha);
        check("fwd1_cyc", cyc, 4);
        check("fwd1_coll", nc, 0);
        check("fwd1_x", int'(pos_x), 1);
        check("fwd1_under_held", int'(under), 0);
        @(negedge clock);
        check("fwd1_under", int'(under), 1);
        check("fwd1_barrier", int'(barrier), 1);
        check("fwd1_head", int'(head), 0);
        check("fwd1_left", int'(left), 1);

        // obstacle ahead blocks the move
        issue(1'b1, 1'b0, 1'b0);
        run_busy(cyc, nc, ha);
        check("blk_cyc", cyc, 4);
        check("blk_coll", nc, 1);
        check("blk_x", int'(pos_x), 1);
        @(negedge clock);
        check("blk_coll_low", int'(collision), 0);

        issue(1'b0, 1'b0, 1'b1);
        run_busy(cyc, nc, ha);
        check("rm_cyc", cyc, 6);
        check("rm_obst", int'(obst_left), 0);
        @(negedge clock);
        check("rm_barrier", int'(barrier), 0);

        issue(1'b1, 1'b0, 1'b0);
        run_busy(cyc, nc, ha);
        check("fwd2_coll", nc, 0);
        check("fwd2_x", int'(pos_x), 2);
        @(negedge clock);
        check("fwd2_under", int'(under), 0);
        check("fwd2_head", int'(head), 0);

        do_turn("t1", 2, 1, 0);
        do_turn("t2", 3, 0, 1);
        do_turn("t3", 0, 1, 0);
        do_turn("t4", 1, 0, 1);

        issue(1'b1, 1'b1, 1'b0);
        check("ill_pulse", int'(illegal_cmd), 1);
        check("ill_busy", int'(busy), 0);
        @(negedge clock);
        check("ill_low", int'(illegal_cmd), 0);
        check("ill_x", int'(pos_x), 2);
        check("ill_hdg", int'(heading), 1);

        // reset in the middle of a move
        issue(1'b1, 1'b0, 1'b0);
        @(negedge clock);
        check("mid_busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("mrst_x", int'(pos_x), 0);
        check("mrst_y", int'(pos_y), 0);
        check("mrst_hdg", int'(heading), 1);
        check("mrst_busy", int'(busy), 0);
        check("mrst_obst", int'(obst_left), 1);
        check("mrst_left", int'(left), 1);
        @(negedge clock);
        reset = 1'b0;

        do_turn("w1", 2, 0, 0);
        do_turn("w2", 3, 1, 0);
        issue(1'b1, 1'b0, 1'b0);
        run_busy(cyc, nc, ha);
        check("edge_cyc", cyc, 4);
        check("edge_coll", nc, 1);
        check("edge_head_all", ha, 1);
        check("edge_x", int'(pos_x), 0);
        @(negedge clock);
        check("edge_head", int'(head), 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
